// File: rtl/trakball_pkg.sv
// Shared types, constants and arithmetic helpers for the trackball step emulator.
package trakball_pkg;

    typedef enum logic {
        MODE_DIR_CLK = 1'b0,
        MODE_QUAD    = 1'b1
    } mode_e;

    // Quadrature phase {a,b} for counter values 0..3, packed two bits per entry.
    localparam logic [7:0] GRAY_LUT     = 8'b10_11_01_00;
    localparam int         ACCEL_THRESH = 16;

    // Symmetric clamp to +/-(2^(acc_w-1)-1) so the most-negative code never appears.
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] acc,
        input logic signed [31:0] inc,
        input int                 acc_w
    );
        logic signed [31:0] lim;
        logic signed [31:0] sum;
        lim = (32'sd1 <<< (acc_w - 1)) - 32'sd1;
        sum = acc + inc;
        if (sum > lim) begin
            sat_add = lim;
        end else if (sum < -lim) begin
            sat_add = -lim;
        end else begin
            sat_add = sum;
        end
    endfunction

    function automatic logic [1:0] gray2(input logic [1:0] cnt);
        gray2 = GRAY_LUT[{cnt, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/trakball_axis.sv
// One trackball axis: saturating delta accumulator, 2-bit step counter and output mapping.
// Build option TRAK_ACCEL_EN doubles large deltas before accumulation.
module trakball_axis
    import trakball_pkg::*;
#(
    parameter int DELTA_W = 8,
    parameter int ACC_W   = 12
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               pkt,
    input  logic               tick,
    input  logic               hold,
    input  mode_e              mode,
    input  logic [DELTA_W-1:0] mag,
    input  logic               neg,
    output logic               out_a,
    output logic               out_b,
    output logic               acc_nz
);

    logic signed [ACC_W-1:0]   acc_r;
    logic signed [ACC_W-1:0]   acc_nxt_s;
    logic [1:0]                cnt_r;
    logic                      dir_r;
    logic                      out_a_r;
    logic                      out_b_r;
    logic signed [DELTA_W:0]   raw_s;
    logic signed [31:0]        d_s;
    logic signed [31:0]        inc_s;
    logic                      step_s;
    logic                      pos_s;
    logic [1:0]                gray_s;

    // Delta decode, step decision and next accumulator value.
    always_comb begin
        raw_s = {neg, mag};
`ifdef TRAK_ACCEL_EN
        d_s = (mag > DELTA_W'(ACCEL_THRESH)) ? (32'(raw_s) <<< 1) : 32'(raw_s);
`else
        d_s = 32'(raw_s);
`endif
        step_s    = tick & ~hold & (acc_r != {ACC_W{1'b0}});
        pos_s     = ~acc_r[ACC_W-1];
        inc_s     = (pkt ? d_s : 32'sd0) - (step_s ? (pos_s ? 32'sd1 : -32'sd1) : 32'sd0);
        acc_nxt_s = ACC_W'(sat_add(32'(acc_r), inc_s, ACC_W));
        acc_nz    = (acc_nxt_s != {ACC_W{1'b0}});
        gray_s    = gray2(cnt_r);
    end

    // Axis state and registered outputs; outputs follow the counter by one cycle.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            acc_r   <= {ACC_W{1'b0}};
            cnt_r   <= 2'd0;
            dir_r   <= 1'b0;
            out_a_r <= 1'b0;
            out_b_r <= 1'b0;
        end else begin
            acc_r <= acc_nxt_s;
            if (step_s) begin
                cnt_r <= pos_s ? (cnt_r + 2'd1) : (cnt_r - 2'd1);
                dir_r <= pos_s;
            end
            out_a_r <= (mode == MODE_QUAD) ? gray_s[1] : dir_r;
            out_b_r <= (mode == MODE_QUAD) ? gray_s[0] : cnt_r[0];
        end
    end

    assign out_a = out_a_r;
    assign out_b = out_b_r;

endmodule

// File: rtl/trakball_quad.sv
// N-axis trackball emulator: packet detect, shared step prescaler and busy flag.
// Build option TRAK_ACCEL_EN enables delta acceleration inside each axis.
module trakball_quad
    import trakball_pkg::*;
#(
    parameter int AXES    = 2,
    parameter int DELTA_W = 8,
    parameter int ACC_W   = 12,
    parameter int DIV_W   = 3
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic                    strobe,
    input  logic [AXES*DELTA_W-1:0] delta,
    input  logic [AXES-1:0]         delta_sign,
    input  logic [AXES-1:0]         invert,
    input  logic [DIV_W-1:0]        sense,
    input  logic                    mode,
    input  logic                    hold,
    output logic [AXES-1:0]         out_a,
    output logic [AXES-1:0]         out_b,
    output logic                    busy
);

    logic              strobe_q_r;
    logic [DIV_W-1:0]  pre_r;
    logic              busy_r;
    logic              pkt_s;
    logic              tick_s;
    logic [AXES-1:0]   acc_nz_s;

    assign pkt_s  = (strobe != strobe_q_r);
    assign tick_s = (pre_r == sense);

    // Packet edge history, prescaler (wraps freely if sense drops below it) and busy.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            strobe_q_r <= 1'b0;
            pre_r      <= {DIV_W{1'b0}};
            busy_r     <= 1'b0;
        end else begin
            strobe_q_r <= strobe;
            pre_r      <= tick_s ? {DIV_W{1'b0}} : (pre_r + DIV_W'(1));
            busy_r     <= |acc_nz_s;
        end
    end

    for (genvar i = 0; i < AXES; i++) begin : g_axis
        trakball_axis #(
            .DELTA_W (DELTA_W),
            .ACC_W   (ACC_W)
        ) u_axis (
            .clk_sys (clk_sys),
            .reset_n (reset_n),
            .pkt     (pkt_s),
            .tick    (tick_s),
            .hold    (hold),
            .mode    (mode_e'(mode)),
            .mag     (delta[i*DELTA_W +: DELTA_W]),
            .neg     (delta_sign[i] ^ invert[i]),
            .out_a   (out_a[i]),
            .out_b   (out_b[i]),
            .acc_nz  (acc_nz_s[i])
        );
    end

    assign busy = busy_r;

endmodule

// File: tb/tb_trakball_quad.sv
// Self-checking bench for trakball_quad: directed vector table, corner sequences, random run.
module tb_trakball_quad;

    localparam int AXES    = 2;
    localparam int DELTA_W = 8;
    localparam int ACC_W   = 10;
    localparam int DIV_W   = 3;
    localparam int LIM     = 511;

    logic                    clk_sys;
    logic                    reset_n;
    logic                    strobe;
    logic [AXES*DELTA_W-1:0] delta;
    logic [AXES-1:0]         delta_sign;
    logic [AXES-1:0]         invert;
    logic [DIV_W-1:0]        sense;
    logic                    mode;
    logic                    hold;
    logic [AXES-1:0]         out_a;
    logic [AXES-1:0]         out_b;
    logic                    busy;

    trakball_quad #(
        .AXES(AXES), .DELTA_W(DELTA_W), .ACC_W(ACC_W), .DIV_W(DIV_W)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .strobe(strobe), .delta(delta),
        .delta_sign(delta_sign), .invert(invert), .sense(sense), .mode(mode),
        .hold(hold), .out_a(out_a), .out_b(out_b), .busy(busy)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    // Reference model: integer accumulator and unbounded position per axis.
    int  m_acc  [AXES];
    int  m_pos  [AXES];
    bit  m_dir  [AXES];
    bit  m_oa   [AXES];
    bit  m_ob   [AXES];
    bit  m_busy;
    bit  m_sq;
    int  m_pre;

    // Observation of the DUT outputs.
    logic [AXES-1:0] prev_b;
    int              tog [AXES];
    int              cyc_n = 0;
    logic [1:0]      q_prev;
    logic [1:0]      q_seq [$];
    int              q_t   [$];

    function automatic int dval(int ax);
        int mag;
        bit sg;
        mag = int'(delta[ax*DELTA_W +: DELTA_W]);
        sg  = delta_sign[ax] ^ invert[ax];
`ifdef TRAK_ACCEL_EN
        if (mag > 16) return 2 * (sg ? mag - 256 : mag);
`endif
        return sg ? mag - 256 : mag;
    endfunction

    function automatic logic [1:0] quad_of(int pos);
        case (pos & 3)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    function automatic int clamp(int x);
        if (x > LIM) return LIM;
        if (x < -LIM) return -LIM;
        return x;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc_n);
        end
    endtask

    task automatic model_reset();
        for (int ax = 0; ax < AXES; ax++) begin
            m_acc[ax] = 0; m_pos[ax] = 0; m_dir[ax] = 0; m_oa[ax] = 0; m_ob[ax] = 0;
        end
        m_busy = 0; m_sq = 0; m_pre = 0;
    endtask

    // One clock: advance the model with the inputs present at the edge, then compare.
    task automatic cyc();
        bit pkt, tick;
        int s;
        logic [AXES-1:0] ea, eb;
        logic [1:0] q;
        @(posedge clk_sys);
        #1;
        cyc_n++;
        if (reset_n) begin
            pkt   = (strobe != m_sq);
            m_sq  = strobe;
            tick  = (m_pre == int'(sense));
            m_pre = tick ? 0 : (m_pre + 1) % 8;
            m_busy = 0;
            for (int ax = 0; ax < AXES; ax++) begin
                q = quad_of(m_pos[ax]);
                m_oa[ax] = mode ? q[1] : m_dir[ax];
                m_ob[ax] = mode ? q[0] : m_pos[ax][0];
                s = 0;
                if (tick && !hold && m_acc[ax] != 0) s = (m_acc[ax] > 0) ? 1 : -1;
                if (s != 0) begin
                    m_pos[ax] += s;
                    m_dir[ax] = (s > 0);
                end
                m_acc[ax] = clamp(m_acc[ax] + (pkt ? dval(ax) : 0) - s);
                if (m_acc[ax] != 0) m_busy = 1;
            end
        end
        for (int ax = 0; ax < AXES; ax++) begin
            ea[ax] = m_oa[ax];
            eb[ax] = m_ob[ax];
        end
        check("model_outputs", 32'({out_a, out_b, busy}), 32'({ea, eb, m_busy}));
        for (int ax = 0; ax < AXES; ax++)
            if (out_b[ax] !== prev_b[ax]) tog[ax]++;
        prev_b = out_b;
        if ({out_a[1], out_b[1]} !== q_prev) begin
            q_seq.push_back({out_a[1], out_b[1]});
            q_t.push_back(cyc_n);
        end
        q_prev = {out_a[1], out_b[1]};
    endtask

    task automatic do_reset(bit keep_strobe);
        #2;
        reset_n = 1'b0;
        if (!keep_strobe) strobe = 1'b0;
        #1;
        model_reset();
        check("reset_outputs", 32'({out_a, out_b, busy}), 32'd0);
        prev_b = '0;
        q_prev = 2'b00;
        q_seq.delete();
        q_t.delete();
        for (int ax = 0; ax < AXES; ax++) tog[ax] = 0;
        @(posedge clk_sys);
        #2;
        reset_n = 1'b1;
    endtask

    task automatic send_pkt(int ax, logic [7:0] mag, bit sg);
        delta      = '0;
        delta_sign = '0;
        delta[ax*DELTA_W +: DELTA_W] = mag;
        delta_sign[ax] = sg;
        strobe = ~strobe;
        cyc();
    endtask

    task automatic run_idle(int budget, string name);
        bit done = 0;
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (busy === 1'b0) begin
                done = 1;
                break;
            end
        end
        check({name, "_idle"}, 32'(done), 32'd1);
        for (int i = 0; i < 3; i++) cyc();
    endtask

    typedef struct {
        logic [7:0] mag;
        bit         sg;
        bit         inv;
        logic [2:0] sns;
        int         exp_steps;
        bit         exp_dir;
    } vec_t;

    vec_t vecs [7];

    initial begin
        reset_n = 1'b0; strobe = 1'b0; delta = '0; delta_sign = '0; invert = '0;
        sense = 3'd0; mode = 1'b0; hold = 1'b0;

        vecs[0] = '{8'd5,   1'b0, 1'b0, 3'd0, 5,   1'b1};
        vecs[1] = '{8'd253, 1'b1, 1'b0, 3'd1, 3,   1'b0};
        vecs[2] = '{8'd0,   1'b1, 1'b0, 3'd0, 256, 1'b0};
        vecs[3] = '{8'd1,   1'b0, 1'b1, 3'd0, 255, 1'b0};
        vecs[4] = '{8'd200, 1'b1, 1'b1, 3'd2, 200, 1'b1};
        vecs[5] = '{8'd0,   1'b0, 1'b0, 3'd0, 0,   1'b0};
        vecs[6] = '{8'd17,  1'b0, 1'b0, 3'd7, 17,  1'b1};

        // Single packet on axis 0 in DIR_CLK mode: step count and final direction.
        for (int v = 0; v < 7; v++) begin
            do_reset(1'b0);
            mode = 1'b0;
            sense = vecs[v].sns;
            invert = {1'b0, vecs[v].inv};
            send_pkt(0, vecs[v].mag, vecs[v].sg);
            run_idle(vecs[v].exp_steps * (int'(vecs[v].sns) + 1) + 20, "vec");
            check("vec_steps", 32'(tog[0]), 32'(vecs[v].exp_steps));
            check("vec_dir", 32'(out_a[0]), 32'(vecs[v].exp_dir));
            check("vec_busy", 32'(busy), 32'd0);
            invert = '0;
        end

        // QUAD mode, axis 1 moves -3 with steps every 4 clocks.
        do_reset(1'b0);
        mode = 1'b1; sense = 3'd3;
        send_pkt(1, 8'd253, 1'b1);
        run_idle(60, "quad");
        check("quad_len", 32'(q_seq.size()), 32'd3);
        if (q_seq.size() == 3) begin
            check("quad_seq", 32'({q_seq[0], q_seq[1], q_seq[2]}), 32'(6'b10_11_01));
            check("quad_gap1", 32'(q_t[1] - q_t[0]), 32'd4);
            check("quad_gap2", 32'(q_t[2] - q_t[1]), 32'd4);
        end
        mode = 1'b0;

        // Saturation: three +255 packets while held clamp at +511.
        do_reset(1'b0);
        sense = 3'd0; hold = 1'b1;
        for (int k = 0; k < 3; k++) send_pkt(0, 8'd255, 1'b0);
        cyc(); cyc();
        check("sat_busy", 32'(busy), 32'd1);
        hold = 1'b0;
        run_idle(700, "sat");
        check("sat_steps", 32'(tog[0]), 32'd511);

        // Packet and step in the same cycle: acc 1 + 2 - 1 = 2, three steps in total.
        do_reset(1'b0);
        sense = 3'd0; hold = 1'b1;
        send_pkt(0, 8'd1, 1'b0);
        cyc();
        hold = 1'b0;
        send_pkt(0, 8'd2, 1'b0);
        check("same_busy", 32'(busy), 32'd1);
        run_idle(30, "same");
        check("same_steps", 32'(tog[0]), 32'd3);

        // Hold: nothing moves for 50 cycles, then four steps.
        do_reset(1'b0);
        sense = 3'd0; hold = 1'b1;
        send_pkt(0, 8'd4, 1'b0);
        for (int k = 0; k < 50; k++) cyc();
        check("hold_steps", 32'(tog[0]), 32'd0);
        hold = 1'b0;
        run_idle(30, "hold");
        check("hold_release_steps", 32'(tog[0]), 32'd4);

        // Strobe high at reset release counts as a packet.
        strobe = 1'b1;
        delta = '0; delta_sign = '0;
        delta[0 +: DELTA_W] = 8'd3;
        do_reset(1'b1);
        run_idle(30, "strobe_rst");
        check("strobe_rst_steps", 32'(tog[0]), 32'd3);

        // Inverted axis steps in reverse; reset mid-stream clears everything at once.
        do_reset(1'b0);
        sense = 3'd0; invert = 2'b01;
        send_pkt(0, 8'd6, 1'b0);
        for (int k = 0; k < 10; k++) cyc();
        check("inv_dir", 32'(out_a[0]), 32'd0);
        check("inv_moving", 32'(tog[0] >= 4), 32'd1);
        do_reset(1'b0);
        invert = '0;

        // Randomised traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                for (int ax = 0; ax < AXES; ax++)
                    delta[ax*DELTA_W +: DELTA_W] = 8'($urandom_range(0, 255));
                delta_sign = 2'($urandom);
                strobe = ~strobe;
            end
            if ($urandom_range(0, 40) == 0)  hold = ~hold;
            if ($urandom_range(0, 80) == 0)  sense = 3'($urandom);
            if ($urandom_range(0, 100) == 0) mode = ~mode;
            if ($urandom_range(0, 150) == 0) invert = 2'($urandom);
            if ($urandom_range(0, 700) == 0) do_reset($urandom_range(0, 1) == 1);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trakball_quad.md
Name: trakball_quad

Overview:
- Parametrised trackball emulator that converts per-packet relative mouse deltas into paced per-axis step streams for arcade trackball inputs.
- Generalises the single 2-axis direction/clock converter to N axes.
- Adds a per-axis invert, an explicit saturating accumulator, a selectable true-quadrature output mode and a hold input.
- Sits between hps_io mouse data and the game core trackball input bus, in the clk_sys domain.

Parameters:
- AXES, 2, number of independent axes.
- DELTA_W, 8, magnitude width of incoming delta per axis (sign supplied separately).
- ACC_W, 12, signed accumulator width per axis.
- DIV_W, 3, width of sensitivity prescaler.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- strobe  in  1  packet toggle; every level change marks a new packet.
- delta  in  AXES*DELTA_W  per-axis delta magnitude bits, axis i at [i*DELTA_W +: DELTA_W].
- delta_sign  in  AXES  per-axis sign (1 = negative).
- invert  in  AXES  per-axis direction invert, XORed with delta_sign.
- sense  in  DIV_W  step period = sense+1 clocks.
- mode  in  1  0 = DIR_CLK, 1 = QUAD.
- hold  in  1  1 = suppress stepping (pause).
- out_a  out  AXES  DIR_CLK: direction; QUAD: phase A.
- out_b  out  AXES  DIR_CLK: step clock; QUAD: phase B.
- busy  out  1  OR of all accumulators nonzero.

Behaviour:
- Reset (async, reset_n=0):
  - accumulators = 0, step counters = 0, direction regs = 0, prescaler = 0, strobe_q = 0.
  - out_a = 0, out_b = 0, busy = 0.
  - A strobe level of 1 seen after reset release counts as a packet.
- Packet detect: strobe_q <= strobe every cycle. pkt = (strobe != strobe_q).
- Delta: d_i = signed {sign^invert, magnitude}, sign-extended to ACC_W+1 bits. Two's-complement form of the original 9-bit value.
- Prescaler: tick = (prescaler == sense). On tick prescaler <= 0, else +1. If sense changes below the current count, prescaler wraps through 2^DIV_W to 0. sense = 0 gives a tick every cycle.
- Step per axis: step_i = tick & ~hold & (acc_i != 0). step direction s_i = +1 if acc_i > 0, -1 if acc_i < 0.
- Accumulator update, one cycle, computed in ACC_W+2 bits: acc_i <= sat(acc_i + (pkt ? d_i : 0) - (step_i ? s_i : 0)).
  - sat clamps to [-(2^(ACC_W-1)-1), +(2^(ACC_W-1)-1)].
  - The most-negative code is never produced.
  - Simultaneous packet and step are both applied in the same cycle.
- On step_i: cnt_i (2-bit) <= cnt_i + s_i (mod 4); dir_i <= (s_i > 0).
- Outputs, registered, updated the cycle after the counter update:
  - DIR_CLK: out_a = dir_i, out_b = cnt_i[0]. One step gives exactly one out_b transition.
  - QUAD: {out_a, out_b} = gray(cnt_i), sequence 00, 01, 11, 10 forward; reverse for negative.
  - mode switch mid-stream: no state reset; the new mapping appears one cycle later.
- Latency: a packet at cycle n updates acc at n+1. The first step occurs at the first tick after that; its output appears 2 cycles after the tick.
- hold=1: packets still accumulate (saturating), no steps. Stepping resumes on the first tick after hold falls.
- busy is registered: busy = |acc after update.

Optional Feature:
- Macro TRAK_ACCEL_EN.
- Defined: if delta magnitude > 16, d_i is doubled before accumulation, still saturated.
- Undefined: deltas are added 1:1 and no comparator or shifter is built.

Decomposition:
- Package trakball_pkg:
  - mode enum {MODE_DIR_CLK, MODE_QUAD}.
  - gray lookup constant for 2-bit cnt.
  - sat_add function parameterised on ACC_W.
  - ACCEL_THRESH = 16.
- Sub-module trakball_axis: one axis (accumulator, step counter, dir, output mapping), generated AXES times.
- Top holds the prescaler, packet edge detect and busy OR.

Test Plan:
- Reset, then sense=0, mode=0, one packet axis0 +5 → out_b axis0 toggles 5 times on consecutive-cycle ticks, out_a=1; acc reaches 0 and busy falls to 0.
- mode=1, axis1 packet -3, sense=3 → out_a/out_b axis1 go 00→10→11→01 with steps 4 cycles apart.
- Three packets of +255 with ACC_W=10 → acc clamps at +511, never wraps; exactly 511 steps emitted.
- Packet and tick in the same cycle with acc=+1, delta=+2 → acc=+2 next cycle and one step emitted.
- hold=1 during packet +4, hold released after 50 cycles → no steps while held, then 4 steps.
- invert[0]=1, packet +6 → out_a axis0 = 0 and 6 reverse steps; reset_n pulsed mid-stream → all outputs and busy are 0 immediately.
